mux2_rr_arbiter: RTL and testbench
==================================

Name: mux2_rr_arbiter

Overview:
- Two-requester round-robin arbiter that shares one 2:1 mux datapath between requester 0 and requester 1.
- Drives the mux select from a grant FSM.
- Registers the selected data onto a single shared output with a valid flag.
- Enforces a maximum hold time so neither requester can starve the other.

Parameters:
- DATA_W, 8, width of each requester data bus and of the shared output.
- MAX_HOLD, 4, maximum consecutive grant cycles while the other requester waits. Legal values: 2..255.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  2  req[i] high while requester i wants the resource.
- din0  input  DATA_W  requester 0 data.
- din1  input  DATA_W  requester 1 data.
- gnt  output  2  one-hot grant, registered; 00 when idle.
- sel  output  1  mux select, registered; 0 selects din0, 1 selects din1.
- out  output  DATA_W  registered mux output.
- out_vld  output  1  out holds valid data from the granted requester.

Behaviour:
- Reset (async, rst high): state=IDLE, gnt=00, sel=0, out=0, out_vld=0, hold_cnt=0, last=1 (so requester 0 wins the first contention).
- States: IDLE, G0, G1. gnt=01 in G0, gnt=10 in G1, 00 in IDLE. sel=1 only in G1; in IDLE sel keeps its last value.
- IDLE transitions:
  - req=01 -> G0.
  - req=10 -> G1.
  - req=11 -> grant the requester != last.
  - req=00 -> stay in IDLE.
- G0 transitions (G1 symmetric):
  - req[0]=0: go to G1 if req[1], else IDLE.
  - req[0]=1, hold_cnt==MAX_HOLD-1, req[1]=1: forced switch to G1.
  - req[0]=1, hold_cnt==MAX_HOLD-1, req[1]=0: stay in G0, hold_cnt -> 0.
  - Otherwise: stay, hold_cnt+1.
- Switching between G0 and G1 is direct, with no idle bubble.
- hold_cnt clears on every state change. last updates to the new owner on entry to G0/G1.
- Datapath, each edge:
  - out <= (state==G1) ? din1 : din0, evaluated with the current state.
  - out_vld <= (state==G0 & req[0]) | (state==G1 & req[1]).
  - Otherwise out_vld <= 0 and out holds its value.
- Latency: req rises before edge N -> gnt asserted after edge N -> first out_vld after edge N+1.
- A requester dropping req in the same cycle as its grant produces no out_vld for that cycle.
- Simultaneous release and other request: the handover takes effect at the same edge; out_vld stays continuous only if the new owner's data is captured next cycle. A one-cycle out_vld gap at handover is required behaviour.
- gnt is never 11. gnt changes only on clock edges.
- Reset asserted mid-grant: all outputs return to reset values immediately, without waiting for a clock edge.

Optional Feature:
- Macro: MUX2_RR_ARBITER_STATS_EN.
- When defined:
  - Adds outputs gnt_cnt0 and gnt_cnt1, 16 bits each.
  - gnt_cnt0 increments on each entry into G0; gnt_cnt1 on each entry into G1.
  - Counters saturate at 16'hFFFF and clear on rst.
  - Staying in a state after a hold_cnt restart is not an entry.
- When undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset check: rst=1 asynchronously mid-cycle with req=11 -> gnt=00, sel=0, out=0, out_vld=0 immediately; after release with req=11 -> G0 first (gnt=01).
- Single requester: req=01, din0=8'hA5 held 3 cycles -> gnt=01 one edge later; out=8'hA5, out_vld=1 from the following edge for 3 cycles; req drop -> gnt=00, out_vld=0 next edge.
- Contention fairness: req=11 continuously, MAX_HOLD=4 -> gnt sequence 01×4, 10×4, 01×4; sel toggles accordingly; out alternates din0/din1 with 1-cycle lag.
- Hold restart: req=01 for 10 cycles -> gnt stays 01 throughout; no gaps in out_vld.
- Direct handover: G0 active, req changes 01 -> 10 in one cycle -> gnt 01 -> 10 on the same edge, never 00 or 11; out captures din1 (8'h3C) on the next edge.
- Stats (macro defined): 3 full contention rotations from reset -> gnt_cnt0=3, gnt_cnt1=3; forced 65536 entries on one side -> that counter holds at 16'hFFFF.

Source files
------------

// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin arbiter driving a shared, registered 2:1 data mux with a hold limit.
// Optional grant-entry counters are enabled by defining MUX2_RR_ARBITER_STATS_EN.
module mux2_rr_arbiter #(
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        req_i,
    input  logic [DATA_W-1:0] din0_i,
    input  logic [DATA_W-1:0] din1_i,
    output logic [1:0]        gnt_o,
    output logic              sel_o,
    output logic [DATA_W-1:0] out_o,
    output logic              out_vld_o
`ifdef MUX2_RR_ARBITER_STATS_EN
    ,
    output logic [15:0]       gnt_cnt0_o,
    output logic [15:0]       gnt_cnt1_o
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t              state_q, state_d;
    logic [7:0]          hold_q, hold_d;
    logic                last_q, last_d;
    logic [1:0]          gnt_q, gnt_d;
    logic                sel_q, sel_d;
    logic [DATA_W-1:0]   out_q, out_d;
    logic                vld_q, vld_d;

    // Next-state and hold-counter logic; hold_cnt restarts on every state change.
    always_comb begin
        state_d = state_q;
        hold_d  = 8'd0;
        case (state_q)
            IDLE: begin
                case (req_i)
                    2'b01:   state_d = G0;
                    2'b10:   state_d = G1;
                    2'b11:   state_d = last_q ? G0 : G1;
                    default: state_d = IDLE;
                endcase
            end
            G0: begin
                if (!req_i[0]) begin
                    state_d = req_i[1] ? G1 : IDLE;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = req_i[1] ? G1 : G0;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            G1: begin
                if (!req_i[1]) begin
                    state_d = req_i[0] ? G0 : IDLE;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = req_i[0] ? G0 : G1;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the next state so gnt/sel line up with the state register.
    always_comb begin
        case (state_d)
            G0:      begin gnt_d = 2'b01; sel_d = 1'b0;  last_d = 1'b0;   end
            G1:      begin gnt_d = 2'b10; sel_d = 1'b1;  last_d = 1'b1;   end
            default: begin gnt_d = 2'b00; sel_d = sel_q; last_d = last_q; end
        endcase
    end

    // Datapath capture uses the current owner; out holds when nothing valid is captured.
    always_comb begin
        vld_d = ((state_q == G0) && req_i[0]) || ((state_q == G1) && req_i[1]);
        if (vld_d) begin
            out_d = (state_q == G1) ? din1_i : din0_i;
        end else begin
            out_d = out_q;
        end
    end

    // Grant FSM and all registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            hold_q  <= 8'd0;
            last_q  <= 1'b1;
            gnt_q   <= 2'b00;
            sel_q   <= 1'b0;
            out_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            out_q   <= out_d;
            vld_q   <= vld_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign sel_o     = sel_q;
    assign out_o     = out_q;
    assign out_vld_o = vld_q;

`ifdef MUX2_RR_ARBITER_STATS_EN
    logic [15:0] cnt0_q, cnt1_q;
    logic        enter_g0_s, enter_g1_s;

    assign enter_g0_s = (state_d == G0) && (state_q != G0);
    assign enter_g1_s = (state_d == G1) && (state_q != G1);

    // Saturating entry counters; a hold restart within the same state is not an entry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt0_q <= 16'd0;
            cnt1_q <= 16'd0;
        end else begin
            if (enter_g0_s && (cnt0_q != 16'hFFFF)) begin
                cnt0_q <= cnt0_q + 16'd1;
            end
            if (enter_g1_s && (cnt1_q != 16'hFFFF)) begin
                cnt1_q <= cnt1_q + 16'd1;
            end
        end
    end

    assign gnt_cnt0_o = cnt0_q;
    assign gnt_cnt1_o = cnt1_q;
`endif

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed, table-driven bench for mux2_rr_arbiter (MAX_HOLD=4, DATA_W=8).
module tb_mux2_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [7:0]  din0, din1;
    logic [1:0]  gnt;
    logic        sel;
    logic [7:0]  dout;
    logic        out_vld;
`ifdef MUX2_RR_ARBITER_STATS_EN
    logic [15:0] cnt0, cnt1;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] req;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [1:0] gnt;
        logic       sel;
        logic [7:0] out;
        logic       vld;
    } vec_t;

    vec_t vecs [28];

    mux2_rr_arbiter #(.DATA_W(8), .MAX_HOLD(4)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .req_i     (req),
        .din0_i    (din0),
        .din1_i    (din1),
        .gnt_o     (gnt),
        .sel_o     (sel),
        .out_o     (dout),
        .out_vld_o (out_vld)
`ifdef MUX2_RR_ARBITER_STATS_EN
        ,
        .gnt_cnt0_o(cnt0),
        .gnt_cnt1_o(cnt1)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%h exp=%h", name, idx, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [1:0] r, input logic [7:0] a, input logic [7:0] b,
                           input logic [1:0] g, input logic s, input logic [7:0] o, input logic vl);
        vecs[i] = '{r, a, b, g, s, o, vl};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag, input int idx, input logic [1:0] g, input logic s,
                            input logic [7:0] o, input logic vl);
        chk({tag, "_gnt"}, idx, {14'd0, gnt}, {14'd0, g});
        chk({tag, "_sel"}, idx, {15'd0, sel}, {15'd0, s});
        chk({tag, "_out"}, idx, {8'd0, dout}, {8'd0, o});
        chk({tag, "_vld"}, idx, {15'd0, out_vld}, {15'd0, vl});
    endtask

    initial begin
        // Contention rotation from reset: G0 first, four cycles each side.
        set_vec(0,  2'b11, 8'h11, 8'h22, 2'b01, 1'b0, 8'h00, 1'b0);
        for (int i = 1; i <= 3; i++) set_vec(i, 2'b11, 8'h11, 8'h22, 2'b01, 1'b0, 8'h11, 1'b1);
        set_vec(4,  2'b11, 8'h11, 8'h22, 2'b10, 1'b1, 8'h11, 1'b1);
        for (int i = 5; i <= 7; i++) set_vec(i, 2'b11, 8'h11, 8'h22, 2'b10, 1'b1, 8'h22, 1'b1);
        set_vec(8,  2'b11, 8'h11, 8'h22, 2'b01, 1'b0, 8'h22, 1'b1);
        for (int i = 9; i <= 11; i++) set_vec(i, 2'b11, 8'h11, 8'h22, 2'b01, 1'b0, 8'h11, 1'b1);
        // Lone requester past the hold limit: grant restarts, no valid gap.
        for (int i = 12; i <= 19; i++) set_vec(i, 2'b01, 8'hA5, 8'h22, 2'b01, 1'b0, 8'hA5, 1'b1);
        // Direct handover 01 -> 10, then release, drop-on-grant and a fresh G1 grant.
        set_vec(20, 2'b10, 8'hA5, 8'h3C, 2'b10, 1'b1, 8'hA5, 1'b0);
        set_vec(21, 2'b10, 8'hA5, 8'h3C, 2'b10, 1'b1, 8'h3C, 1'b1);
        set_vec(22, 2'b00, 8'hA5, 8'h3C, 2'b00, 1'b1, 8'h3C, 1'b0);
        set_vec(23, 2'b00, 8'hA5, 8'h3C, 2'b00, 1'b1, 8'h3C, 1'b0);
        set_vec(24, 2'b01, 8'h5A, 8'h3C, 2'b01, 1'b0, 8'h3C, 1'b0);
        set_vec(25, 2'b00, 8'h5A, 8'h3C, 2'b00, 1'b0, 8'h3C, 1'b0);
        set_vec(26, 2'b10, 8'h5A, 8'h3C, 2'b10, 1'b1, 8'h3C, 1'b0);
        set_vec(27, 2'b11, 8'h5A, 8'h77, 2'b10, 1'b1, 8'h77, 1'b1);

        rst  = 1'b1;
        req  = 2'b00;
        din0 = 8'h00;
        din1 = 8'h00;
        #1;
        chk_outs("rst0", 0, 2'b00, 1'b0, 8'h00, 1'b0);
        repeat (2) tick();
        rst = 1'b0;
        chk_outs("rst1", 0, 2'b00, 1'b0, 8'h00, 1'b0);

        for (int i = 0; i < 28; i++) begin
            req  = vecs[i].req;
            din0 = vecs[i].d0;
            din1 = vecs[i].d1;
            tick();
            chk_outs("vec", i, vecs[i].gnt, vecs[i].sel, vecs[i].out, vecs[i].vld);
        end

`ifdef MUX2_RR_ARBITER_STATS_EN
        chk("cnt0", 0, cnt0, 16'd3);
        chk("cnt1", 0, cnt1, 16'd3);
`endif

        // Asynchronous reset mid-cycle while G1 holds the grant.
        #2;
        req = 2'b11;
        rst = 1'b1;
        #1;
        chk_outs("arst", 0, 2'b00, 1'b0, 8'h00, 1'b0);
`ifdef MUX2_RR_ARBITER_STATS_EN
        chk("cnt0_rst", 0, cnt0, 16'd0);
        chk("cnt1_rst", 0, cnt1, 16'd0);
`endif
        tick();
        rst  = 1'b0;
        din0 = 8'hC3;
        tick();
        chk_outs("post", 0, 2'b01, 1'b0, 8'h00, 1'b0);
        tick();
        chk_outs("post", 1, 2'b01, 1'b0, 8'hC3, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
